// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2s_pkg
// Description : Shared I2S frame constants and the stereo sample pair type.
// Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    localparam int FRAME_BITS    = 64;
    localparam int SLOT_BITS     = 32;
    localparam int CNT_W         = 6;
    localparam int LEFT_MSB_POS  = 1;
    localparam int RIGHT_MSB_POS = 33;

    // Default channel width of the audio path
    localparam int SAMPLE_W = 24;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } stereo_pair_t;

endpackage
`default_nettype wire

// File: rtl/i2s_frame_timer.sv
`default_nettype none
// ============================================================================
// Module      : i2s_frame_timer
// Description : 64-slot I2S frame counter, registered LRCLK and load strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_frame_timer
    import i2s_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_enable,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_lrclk,
    output logic             o_load
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_lrclk;
    logic [CNT_W-1:0] w_cnt_next;

    always_comb begin
        w_cnt_next = '0;
        if (i_enable) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    // LRCLK is the slot half of the upcoming count so it lines up with cnt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_lrclk <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_lrclk <= w_cnt_next[CNT_W-1];
        end
    end

    assign o_cnt   = r_cnt;
    assign o_lrclk = r_lrclk;
    assign o_load  = i_enable && (r_cnt == LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/i2s_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : i2s_tx_serializer
// Description : Avalon-ST sink to Philips I2S stereo transmitter with a
//               one-pair holding register and underrun accounting.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_tx_serializer
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [2*DATA_WIDTH-1:0] sink_data,
    input  logic                    sink_valid,
    output logic                    sink_ready,
    output logic                    i2s_lrclk,
    output logic                    i2s_dout,
    output logic                    underrun,
    output logic [15:0]             underrun_count
);

    localparam logic [CNT_W-2:0] c_DW = (CNT_W-1)'(DATA_WIDTH);

    logic [CNT_W-1:0]        w_cnt;
    logic                    w_load;
    logic                    w_accept;
    logic                    w_starve;
    logic                    w_in_window;

    logic [2*DATA_WIDTH-1:0] r_hold;
    logic                    r_hold_full;
    logic [2*DATA_WIDTH-1:0] r_shift;
    logic                    r_dout;
    logic                    r_primed;
    logic                    r_underrun;
    logic [15:0]             r_underrun_count;

    i2s_frame_timer u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_enable (enable),
        .o_cnt    (w_cnt),
        .o_lrclk  (i2s_lrclk),
        .o_load   (w_load)
    );

    assign sink_ready = enable & (~r_hold_full | w_load);
    assign w_accept   = sink_valid & sink_ready;
    assign w_starve   = w_load & ~r_hold_full & r_primed;

    // Shift while the next slot position lies inside a channel's sample bits
    assign w_in_window = (w_cnt[CNT_W-2:0] < c_DW);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold      <= sink_data;
            r_hold_full <= 1'b1;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= '0;
            r_dout  <= 1'b0;
        end else if (!enable) begin
            r_shift <= '0;
            r_dout  <= 1'b0;
        end else if (w_load) begin
            r_shift <= r_hold_full ? r_hold : '0;
            r_dout  <= 1'b0;
        end else if (w_in_window) begin
            r_shift <= {r_shift[2*DATA_WIDTH-2:0], 1'b0};
            r_dout  <= r_shift[2*DATA_WIDTH-1];
        end else begin
            r_dout  <= 1'b0;
        end
    end

    // The first load after enable only primes the pipe and never counts as starved
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_primed         <= 1'b0;
            r_underrun       <= 1'b0;
            r_underrun_count <= '0;
        end else begin
            r_underrun <= w_starve;
            if (!enable) begin
                r_primed <= 1'b0;
            end else if (w_load) begin
                r_primed <= 1'b1;
            end
            if (w_starve && (r_underrun_count != 16'hFFFF)) begin
                r_underrun_count <= r_underrun_count + 16'd1;
            end
        end
    end

    assign i2s_dout       = r_dout;
    assign underrun       = r_underrun;
    assign underrun_count = r_underrun_count;

endmodule
`default_nettype wire
